// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling display controller.
//   scroll_state_t : controller FSM states
//   SPACE_CHAR     : blank character used for reset fill and empty messages
//   MIN_PERIOD     : smallest timer load value ever issued
package scroll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2,
        STEP = 2'd3
    } scroll_state_t;

    localparam logic [7:0]  SPACE_CHAR = 8'h20;
    localparam logic [31:0] MIN_PERIOD = 32'd1;

endpackage

// File: rtl/scroll_msg_buf.sv
// Message buffer: async-reset register file, one write port and NUM_DIGITS
// combinational read ports addressed modulo the active message length.
// Ports:
//   clk_i, rst_i   clock / async active-high reset (fills buffer with spaces)
//   wr_en_i        write strobe
//   wr_addr_i      write address
//   wr_data_i      write character
//   rd_base_i      window start index
//   rd_len_i       active length (0..MSG_DEPTH); 0 reads all spaces
//   rd_data_o      NUM_DIGITS characters, digit 0 in the MSBs
module scroll_msg_buf
    import scroll_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_DEPTH  = 16,
    parameter int CHAR_W     = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_en_i,
    input  logic [$clog2(MSG_DEPTH)-1:0]   wr_addr_i,
    input  logic [CHAR_W-1:0]              wr_data_i,
    input  logic [$clog2(MSG_DEPTH)-1:0]   rd_base_i,
    input  logic [$clog2(MSG_DEPTH):0]     rd_len_i,
    output logic [NUM_DIGITS*CHAR_W-1:0]   rd_data_o
);

    localparam int ADDR_W = $clog2(MSG_DEPTH);
    localparam int LEN_W  = ADDR_W + 1;

    logic [CHAR_W-1:0] mem_q [MSG_DEPTH];
    logic [LEN_W-1:0]  idx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < MSG_DEPTH; k++) begin
                mem_q[k] <= CHAR_W'(SPACE_CHAR);
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // The base may exceed the length while idle (msg_len shrank), so it is
    // first reduced by repeated compare-subtract; after that each digit index
    // is just an increment that wraps at the length.
    always_comb begin
        rd_data_o = '0;
        idx       = '0;
        if (rd_len_i == '0) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                rd_data_o[i*CHAR_W +: CHAR_W] = CHAR_W'(SPACE_CHAR);
            end
        end else begin
            idx = {1'b0, rd_base_i};
            for (int k = 0; k < MSG_DEPTH; k++) begin
                if (idx >= rd_len_i) begin
                    idx = idx - rd_len_i;
                end
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                rd_data_o[(NUM_DIGITS-1-i)*CHAR_W +: CHAR_W] = mem_q[idx[ADDR_W-1:0]];
                idx = ((idx + LEN_W'(1)) >= rd_len_i) ? '0 : (idx + LEN_W'(1));
            end
        end
    end

endmodule

// File: rtl/scroll_display_ctrl.sv
// Scrolling display controller. Arms an external scrolling_timer, and on each
// timer expiry advances a window over the message buffer.
// Ports:
//   clk, rst            clock / async active-high reset
//   wr_en/wr_addr/wr_data  bus-side buffer write port
//   msg_len             active message length (0..MSG_DEPTH)
//   period              scroll step period in clk cycles (0 treated as 1)
//   scroll_en           scrolling runs while high
//   cnt_start/cnt_value timer start pulse and load value
//   cnt_done            timer expiry (pulse or level)
//   disp_chars          visible window, digit 0 in the MSBs
//   offset              window start index
//   wrap_pulse          one cycle when offset wraps to 0
//   busy                controller not in IDLE
module scroll_display_ctrl
    import scroll_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_DEPTH  = 16,
    parameter int CHAR_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0]   wr_addr,
    input  logic [CHAR_W-1:0]              wr_data,
    input  logic [$clog2(MSG_DEPTH):0]     msg_len,
    input  logic [31:0]                    period,
    input  logic                           scroll_en,
    output logic                           cnt_start,
    output logic [31:0]                    cnt_value,
    input  logic                           cnt_done,
    output logic [NUM_DIGITS*CHAR_W-1:0]   disp_chars,
    output logic [$clog2(MSG_DEPTH)-1:0]   offset,
    output logic                           wrap_pulse,
    output logic                           busy
);

    localparam int ADDR_W = $clog2(MSG_DEPTH);
    localparam int LEN_W  = ADDR_W + 1;
    localparam int DISP_W = NUM_DIGITS * CHAR_W;

    scroll_state_t     state_q, state_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              cnt_start_q, cnt_start_d;
    logic [31:0]       cnt_value_q, cnt_value_d;
    logic              wrap_q, wrap_d;
    logic              busy_q, busy_d;
    logic              done_q;
    logic [DISP_W-1:0] disp_q;

    logic              done_rise;
    logic [LEN_W-1:0]  len_clip;
    logic [LEN_W-1:0]  rd_len;
    logic [LEN_W-1:0]  off_inc;
    logic [DISP_W-1:0] rd_data;

    assign done_rise = cnt_done && !done_q;
    assign len_clip  = (msg_len > LEN_W'(MSG_DEPTH)) ? LEN_W'(MSG_DEPTH) : msg_len;
    assign rd_len    = busy_q ? len_q : len_clip;
    assign off_inc   = {1'b0, offset_q} + LEN_W'(1);

    scroll_msg_buf #(
        .NUM_DIGITS (NUM_DIGITS),
        .MSG_DEPTH  (MSG_DEPTH),
        .CHAR_W     (CHAR_W)
    ) u_buf (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_base_i (offset_q),
        .rd_len_i  (rd_len),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        len_d       = len_q;
        cnt_value_d = cnt_value_q;
        wrap_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (scroll_en && (msg_len != '0)) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Disable has priority over a coincident expiry.
                if (!scroll_en) begin
                    state_d = IDLE;
                end else if (done_rise) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                if (off_inc >= len_q) begin
                    offset_d = '0;
                    wrap_d   = 1'b1;
                end else begin
                    offset_d = off_inc[ADDR_W-1:0];
                end
                state_d = scroll_en ? ARM : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Work done on entry to ARM so length, load value and start pulse are
        // all valid during the ARM cycle. An offset beyond a shortened message
        // restarts at 0 silently (no wrap pulse).
        if (state_d == ARM) begin
            len_d       = len_clip;
            cnt_value_d = (period == '0) ? MIN_PERIOD : period;
            if ({1'b0, offset_d} >= len_clip) begin
                offset_d = '0;
            end
        end

        cnt_start_d = (state_d == ARM);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            offset_q    <= '0;
            len_q       <= '0;
            cnt_start_q <= 1'b0;
            cnt_value_q <= '0;
            wrap_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            disp_q      <= {NUM_DIGITS{CHAR_W'(SPACE_CHAR)}};
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            len_q       <= len_d;
            cnt_start_q <= cnt_start_d;
            cnt_value_q <= cnt_value_d;
            wrap_q      <= wrap_d;
            busy_q      <= busy_d;
            done_q      <= cnt_done;
            disp_q      <= rd_data;
        end
    end

    assign cnt_start  = cnt_start_q;
    assign cnt_value  = cnt_value_q;
    assign disp_chars = disp_q;
    assign offset     = offset_q;
    assign wrap_pulse = wrap_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Directed testbench for scroll_display_ctrl; the timer is played by the
// bench through cnt_done.
module tb_scroll_display_ctrl;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  msg_len;
    logic [31:0] period;
    logic        scroll_en;
    logic        cnt_start;
    logic [31:0] cnt_value;
    logic        cnt_done;
    logic [31:0] disp_chars;
    logic [3:0]  offset;
    logic        wrap_pulse;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    scroll_display_ctrl #(
        .NUM_DIGITS (4),
        .MSG_DEPTH  (16),
        .CHAR_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .msg_len    (msg_len),
        .period     (period),
        .scroll_en  (scroll_en),
        .cnt_start  (cnt_start),
        .cnt_value  (cnt_value),
        .cnt_done   (cnt_done),
        .disp_chars (disp_chars),
        .offset     (offset),
        .wrap_pulse (wrap_pulse),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // One timer expiry from WAIT: STEP, then ARM with the new offset, then WAIT.
    task automatic step(input string tag, input logic [3:0] exp_off, input logic exp_wrap);
        cnt_done = 1'b1;
        tick();
        cnt_done = 1'b0;
        tick();
        chk({tag, "_off"},   64'(offset),     64'(exp_off));
        chk({tag, "_wrap"},  64'(wrap_pulse), 64'(exp_wrap));
        chk({tag, "_start"}, 64'(cnt_start),  64'd1);
        tick();
        chk({tag, "_wrap_end"},  64'(wrap_pulse), 64'd0);
        chk({tag, "_start_end"}, 64'(cnt_start),  64'd0);
    endtask

    initial begin
        rst       = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        msg_len   = '0;
        period    = '0;
        scroll_en = 1'b0;
        cnt_done  = 1'b0;

        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_disp",   64'(disp_chars), 64'h20202020);
        chk("rst_offset", 64'(offset),     64'd0);
        chk("rst_start",  64'(cnt_start),  64'd0);
        chk("rst_busy",   64'(busy),       64'd0);
        chk("rst_wrap",   64'(wrap_pulse), 64'd0);
        chk("rst_value",  64'(cnt_value),  64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // "HELLO " into the buffer.
        wr(4'd0, 8'h48);
        wr(4'd1, 8'h45);
        wr(4'd2, 8'h4C);
        wr(4'd3, 8'h4C);
        wr(4'd4, 8'h4F);
        wr(4'd5, 8'h20);
        msg_len = 5'd6;
        period  = 32'd10;
        tick();
        chk("idle_disp", 64'(disp_chars), 64'h48454C4C);
        chk("idle_busy", 64'(busy),       64'd0);

        // Arm.
        scroll_en = 1'b1;
        tick();
        chk("arm_start",  64'(cnt_start), 64'd1);
        chk("arm_value",  64'(cnt_value), 64'd10);
        chk("arm_busy",   64'(busy),      64'd1);
        chk("arm_offset", 64'(offset),    64'd0);
        tick();
        chk("wait_start", 64'(cnt_start), 64'd0);

        // First step and full wrap around the 6-character message.
        step("s1", 4'd1, 1'b0);
        chk("s1_disp", 64'(disp_chars), 64'h454C4C4F);
        step("s2", 4'd2, 1'b0);
        step("s3", 4'd3, 1'b0);
        step("s4", 4'd4, 1'b0);
        step("s5", 4'd5, 1'b0);
        step("s6", 4'd0, 1'b1);
        chk("s6_disp", 64'(disp_chars), 64'h48454C4C);

        step("t1", 4'd1, 1'b0);
        step("t2", 4'd2, 1'b0);
        step("t3", 4'd3, 1'b0);
        chk("t3_disp", 64'(disp_chars), 64'h4C4F2048);

        // Disable in WAIT, then a stray expiry.
        scroll_en = 1'b0;
        tick();
        chk("dis_busy", 64'(busy), 64'd0);
        cnt_done = 1'b1;
        tick();
        chk("stray_start", 64'(cnt_start), 64'd0);
        cnt_done = 1'b0;
        tick();
        chk("stray_offset", 64'(offset),     64'd3);
        chk("stray_start2", 64'(cnt_start),  64'd0);
        chk("stray_busy",   64'(busy),       64'd0);
        chk("stray_disp",   64'(disp_chars), 64'h4C4F2048);

        // Re-enable resumes from offset 3.
        scroll_en = 1'b1;
        tick();
        chk("rearm_start",  64'(cnt_start), 64'd1);
        chk("rearm_offset", 64'(offset),    64'd3);
        tick();
        step("r1", 4'd4, 1'b0);
        chk("r1_disp", 64'(disp_chars), 64'h4F204845);

        // Disable and expiry in the same cycle: disable wins.
        scroll_en = 1'b0;
        cnt_done  = 1'b1;
        tick();
        cnt_done = 1'b0;
        tick();
        chk("race_offset", 64'(offset),    64'd4);
        chk("race_busy",   64'(busy),      64'd0);
        chk("race_start",  64'(cnt_start), 64'd0);

        // Short message "AB" repeats across the window.
        wr(4'd0, 8'h41);
        wr(4'd1, 8'h42);
        msg_len = 5'd2;
        tick();
        chk("ab_idle_disp", 64'(disp_chars), 64'h41424142);
        scroll_en = 1'b1;
        tick();
        chk("ab_arm_offset", 64'(offset),     64'd0);
        chk("ab_arm_wrap",   64'(wrap_pulse), 64'd0);
        chk("ab_arm_start",  64'(cnt_start),  64'd1);
        tick();
        chk("ab_disp0", 64'(disp_chars), 64'h41424142);
        step("ab1", 4'd1, 1'b0);
        chk("ab_disp1", 64'(disp_chars), 64'h42414241);
        step("ab2", 4'd0, 1'b1);

        // Zero period loads the minimum value.
        period = 32'd0;
        step("p0", 4'd1, 1'b0);
        chk("p0_value", 64'(cnt_value), 64'd1);

        // cnt_done held high: one step for one rising edge.
        cnt_done = 1'b1;
        tick();
        tick();
        chk("hold_off",  64'(offset),     64'd0);
        chk("hold_wrap", 64'(wrap_pulse), 64'd1);
        tick();
        tick();
        tick();
        chk("hold_off2",  64'(offset),    64'd0);
        chk("hold_start", 64'(cnt_start), 64'd0);
        chk("hold_busy",  64'(busy),      64'd1);
        cnt_done = 1'b0;
        tick();
        step("h1", 4'd1, 1'b0);

        // Zero-length message never leaves IDLE.
        scroll_en = 1'b0;
        tick();
        msg_len   = 5'd0;
        scroll_en = 1'b1;
        tick();
        tick();
        tick();
        chk("len0_busy",  64'(busy),       64'd0);
        chk("len0_start", 64'(cnt_start),  64'd0);
        chk("len0_disp",  64'(disp_chars), 64'h20202020);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
